id_dispatch_buffer: RTL and testbench

//  Decoupling FIFO between the ID-stage operand/register generator and issue/reservation stations.

---
 rtl/id_dispatch_buffer_pkg.sv | 20 ++
 rtl/id_dispatch_buffer_rsid_snoop.sv | 23 ++
 rtl/id_dispatch_buffer.sv | 171 +++++++++++++++++
 tb/tb_id_dispatch_buffer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_dispatch_buffer_pkg.sv
// Shared defaults and sizing helpers for the ID-stage dispatch buffer.
package id_dispatch_buffer_pkg;

  localparam int DEF_DEPTH      = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_RSID_WIDTH = 4;
  localparam int DEF_REG_AW     = 5;
  localparam int DEF_OP_W       = 6;
  localparam int DEF_FUNCT_W    = 6;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/id_dispatch_buffer_rsid_snoop.sv
// Replaces a tagged operand with the CDB result when the broadcast tag matches.
module rsid_snoop
  import id_dispatch_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSID_WIDTH = DEF_RSID_WIDTH
) (
  input  logic                  is_rsid,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  cdb_valid,
  input  logic [RSID_WIDTH-1:0] cdb_rsid,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  snp_is_rsid,
  output logic [DATA_WIDTH-1:0] snp_data
);

  logic hit;

  assign hit         = is_rsid && cdb_valid && (data[RSID_WIDTH-1:0] == cdb_rsid);
  assign snp_is_rsid = is_rsid && !hit;
  assign snp_data    = hit ? cdb_data : data;

endmodule

// File: rtl/id_dispatch_buffer.sv
// Decoupling FIFO between ID and issue; buffered tagged operands snoop the CDB
// and the head is forwarded combinationally so dispatch never sees a stale tag.
module id_dispatch_buffer
  import id_dispatch_buffer_pkg::*;
#(
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int RSID_WIDTH = DEF_RSID_WIDTH,
  parameter  int REG_AW     = DEF_REG_AW,
  parameter  int OP_W       = DEF_OP_W,
  parameter  int FUNCT_W    = DEF_FUNCT_W,
  localparam int CW         = cnt_width(DEPTH),
  localparam int PW         = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [OP_W-1:0]       in_op,
  input  logic [FUNCT_W-1:0]    in_funct,
  input  logic                  in_is_rsid_1,
  input  logic                  in_is_rsid_2,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  input  logic [DATA_WIDTH-1:0] in_data_2,
  input  logic                  in_wr_en,
  input  logic [REG_AW-1:0]     in_wr_addr,
  input  logic                  cdb_valid,
  input  logic [RSID_WIDTH-1:0] cdb_rsid,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [OP_W-1:0]       out_op,
  output logic [FUNCT_W-1:0]    out_funct,
  output logic                  out_is_rsid_1,
  output logic                  out_is_rsid_2,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic [DATA_WIDTH-1:0] out_data_2,
  output logic                  out_wr_en,
  output logic [REG_AW-1:0]     out_wr_addr,
  output logic [CW-1:0]         count
);

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic [DEPTH-1:0] valid;

  logic [ADDR_WIDTH-1:0] pc_q      [DEPTH];
  logic [OP_W-1:0]       op_q      [DEPTH];
  logic [FUNCT_W-1:0]    funct_q   [DEPTH];
  logic [DATA_WIDTH-1:0] d1_q      [DEPTH];
  logic [DATA_WIDTH-1:0] d2_q      [DEPTH];
  logic [REG_AW-1:0]     wr_addr_q [DEPTH];
  logic [DEPTH-1:0]      is1_q, is2_q, wr_en_q;

  logic [DATA_WIDTH-1:0] d1_s [DEPTH];
  logic [DATA_WIDTH-1:0] d2_s [DEPTH];
  logic [DEPTH-1:0]      is1_s, is2_s;

  logic                  enq_is1, enq_is2;
  logic [DATA_WIDTH-1:0] enq_d1, enq_d2;
  logic                  head_is1, head_is2;
  logic [DATA_WIDTH-1:0] head_d1, head_d2;

  logic full, empty, do_enq, do_deq;

  // Occupancy alone decides full/empty; equal pointers are ambiguous.
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign do_enq = in_valid && !full;
  assign do_deq = out_ready && !empty;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = cnt;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    rsid_snoop #(.DATA_WIDTH(DATA_WIDTH), .RSID_WIDTH(RSID_WIDTH)) u_snp_1 (
      .is_rsid(is1_q[g] && valid[g]), .data(d1_q[g]),
      .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
      .snp_is_rsid(is1_s[g]), .snp_data(d1_s[g])
    );
    rsid_snoop #(.DATA_WIDTH(DATA_WIDTH), .RSID_WIDTH(RSID_WIDTH)) u_snp_2 (
      .is_rsid(is2_q[g] && valid[g]), .data(d2_q[g]),
      .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
      .snp_is_rsid(is2_s[g]), .snp_data(d2_s[g])
    );
  end

  rsid_snoop #(.DATA_WIDTH(DATA_WIDTH), .RSID_WIDTH(RSID_WIDTH)) u_enq_snp_1 (
    .is_rsid(in_is_rsid_1), .data(in_data_1),
    .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
    .snp_is_rsid(enq_is1), .snp_data(enq_d1)
  );
  rsid_snoop #(.DATA_WIDTH(DATA_WIDTH), .RSID_WIDTH(RSID_WIDTH)) u_enq_snp_2 (
    .is_rsid(in_is_rsid_2), .data(in_data_2),
    .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
    .snp_is_rsid(enq_is2), .snp_data(enq_d2)
  );

  rsid_snoop #(.DATA_WIDTH(DATA_WIDTH), .RSID_WIDTH(RSID_WIDTH)) u_head_snp_1 (
    .is_rsid(is1_q[rd_ptr]), .data(d1_q[rd_ptr]),
    .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
    .snp_is_rsid(head_is1), .snp_data(head_d1)
  );
  rsid_snoop #(.DATA_WIDTH(DATA_WIDTH), .RSID_WIDTH(RSID_WIDTH)) u_head_snp_2 (
    .is_rsid(is2_q[rd_ptr]), .data(d2_q[rd_ptr]),
    .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
    .snp_is_rsid(head_is2), .snp_data(head_d2)
  );

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      valid  <= '0;
    end else begin
      if (do_enq) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_deq) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: entry payload has no reset; the valid bits and pointers gate it, so
  // clearing the arrays would only add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      is1_q[i] <= is1_s[i];
      is2_q[i] <= is2_s[i];
      d1_q[i]  <= d1_s[i];
      d2_q[i]  <= d2_s[i];
    end
    if (do_enq) begin
      pc_q[wr_ptr]      <= in_pc;
      op_q[wr_ptr]      <= in_op;
      funct_q[wr_ptr]   <= in_funct;
      is1_q[wr_ptr]     <= enq_is1;
      is2_q[wr_ptr]     <= enq_is2;
      d1_q[wr_ptr]      <= enq_d1;
      d2_q[wr_ptr]      <= enq_d2;
      wr_en_q[wr_ptr]   <= in_wr_en;
      wr_addr_q[wr_ptr] <= in_wr_addr;
    end
  end

  // Head fields read as zero while empty so stale payload never leaks out.
  assign out_pc        = out_valid ? pc_q[rd_ptr]      : '0;
  assign out_op        = out_valid ? op_q[rd_ptr]      : '0;
  assign out_funct     = out_valid ? funct_q[rd_ptr]   : '0;
  assign out_is_rsid_1 = out_valid && head_is1;
  assign out_is_rsid_2 = out_valid && head_is2;
  assign out_data_1    = out_valid ? head_d1           : '0;
  assign out_data_2    = out_valid ? head_d2           : '0;
  assign out_wr_en     = out_valid && wr_en_q[rd_ptr];
  assign out_wr_addr   = out_valid ? wr_addr_q[rd_ptr] : '0;

endmodule

// File: tb/tb_id_dispatch_buffer.sv
// Scoreboard bench for id_dispatch_buffer: stimulus pushes expected dispatches,
// a negedge monitor pops and compares each accepted head entry.
module tb_id_dispatch_buffer;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_pc;
  logic [5:0]  in_op, in_funct;
  logic        in_is_rsid_1, in_is_rsid_2;
  logic [31:0] in_data_1, in_data_2;
  logic        in_wr_en;
  logic [4:0]  in_wr_addr;
  logic        cdb_valid;
  logic [3:0]  cdb_rsid;
  logic [31:0] cdb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_op, out_funct;
  logic        out_is_rsid_1, out_is_rsid_2;
  logic [31:0] out_data_1, out_data_2;
  logic        out_wr_en;
  logic [4:0]  out_wr_addr;
  logic [2:0]  count;

  always #5 clk = ~clk;

  id_dispatch_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_op(in_op), .in_funct(in_funct),
    .in_is_rsid_1(in_is_rsid_1), .in_is_rsid_2(in_is_rsid_2),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr),
    .cdb_valid(cdb_valid), .cdb_rsid(cdb_rsid), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op(out_op), .out_funct(out_funct),
    .out_is_rsid_1(out_is_rsid_1), .out_is_rsid_2(out_is_rsid_2),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .count(count)
  );

  typedef struct {
    logic [31:0] pc;
    logic        is1;
    logic [31:0] d1;
    logic        is2;
    logic [31:0] d2;
    logic [4:0]  wa;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic is1, input logic [31:0] d1,
                      input logic is2, input logic [31:0] d2, input logic [4:0] wa);
    exp_t e;
    e.pc = pc; e.is1 = is1; e.d1 = d1; e.is2 = is2; e.d2 = d2; e.wa = wa;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [31:0] pc, input logic is1, input logic [31:0] d1,
                       input logic is2, input logic [31:0] d2, input logic [4:0] wa);
    in_valid     = 1'b1;
    in_pc        = pc;
    in_op        = 6'h09;
    in_funct     = 6'h00;
    in_is_rsid_1 = is1;
    in_data_1    = d1;
    in_is_rsid_2 = is2;
    in_data_2    = d2;
    in_wr_en     = 1'b1;
    in_wr_addr   = wa;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) next_cycle();
    out_ready = 1'b0;
  endtask

  // Every accepted dispatch must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_dispatch: got pc 0x%0h expected none", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("disp_pc",      out_pc,        mon_e.pc);
        check("disp_is1",     out_is_rsid_1, mon_e.is1);
        check("disp_d1",      out_data_1,    mon_e.d1);
        check("disp_is2",     out_is_rsid_2, mon_e.is2);
        check("disp_d2",      out_data_2,    mon_e.d2);
        check("disp_wr_addr", out_wr_addr,   mon_e.wa);
        check("disp_op",      out_op,        6'h09);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_op = '0; in_funct = '0; in_is_rsid_1 = 1'b0; in_is_rsid_2 = 1'b0;
    in_data_1 = '0; in_data_2 = '0; in_wr_en = 1'b0; in_wr_addr = '0;
    cdb_valid = 1'b0; cdb_rsid = '0; cdb_data = '0;

    // Reset state
    next_cycle();
    next_cycle();
    mid();
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count",     count,     0);
    check("rst_out_pc",    out_pc,    0);
    next_cycle();
    rst = 1'b1;

    // Fill with four ADDIU, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + 32'(4 * i), 1'b0, 32'(i), 1'b0, 32'(i + 10), 5'(i + 1));
      push(32'h100 + 32'(4 * i), 1'b0, 32'(i), 1'b0, 32'(i + 10), 5'(i + 1));
      next_cycle();
    end
    in_valid = 1'b0;
    mid();
    check("fill_count",    count,     4);
    check("fill_in_ready", in_ready,  0);
    check("fill_head_pc",  out_pc,    32'h100);
    next_cycle();
    drain(4);
    mid();
    check("drain_count",     count,     0);
    check("drain_out_valid", out_valid, 0);

    // Buffered tags snoop the CDB; non-matching tags leave entries alone
    drive(32'h200, 1'b1, 32'd3, 1'b0, 32'h11, 5'd2);
    next_cycle();
    drive(32'h204, 1'b1, 32'd3, 1'b0, 32'h22, 5'd3);
    next_cycle();
    in_valid  = 1'b0;
    cdb_valid = 1'b1; cdb_rsid = 4'd5; cdb_data = 32'hDEADBEEF;
    mid();
    check("nomatch_fwd_is1", out_is_rsid_1, 1);
    check("nomatch_fwd_d1",  out_data_1,    3);
    next_cycle();
    cdb_valid = 1'b0;
    mid();
    check("nomatch_is1", out_is_rsid_1, 1);
    check("nomatch_d1",  out_data_1,    3);
    next_cycle();
    cdb_valid = 1'b1; cdb_rsid = 4'd3; cdb_data = 32'hDEADBEEF;
    next_cycle();
    cdb_valid = 1'b0;
    mid();
    check("snoop_is1", out_is_rsid_1, 0);
    check("snoop_d1",  out_data_1,    32'hDEADBEEF);
    push(32'h200, 1'b0, 32'hDEADBEEF, 1'b0, 32'h11, 5'd2);
    push(32'h204, 1'b0, 32'hDEADBEEF, 1'b0, 32'h22, 5'd3);
    next_cycle();
    drain(2);

    // Head forward: tag broadcast in the dispatch cycle
    drive(32'h300, 1'b1, 32'd7, 1'b1, 32'd9, 5'd4);
    next_cycle();
    in_valid  = 1'b0;
    push(32'h300, 1'b0, 32'h55, 1'b1, 32'd9, 5'd4);
    cdb_valid = 1'b1; cdb_rsid = 4'd7; cdb_data = 32'h55;
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    cdb_valid = 1'b0;
    mid();
    check("fwd_count", count, 0);
    next_cycle();

    // Enqueue snoop; value operands must ignore a matching CDB
    drive(32'h400, 1'b0, 32'd2, 1'b1, 32'd2, 5'd5);
    cdb_valid = 1'b1; cdb_rsid = 4'd2; cdb_data = 32'h1234;
    next_cycle();
    in_valid = 1'b0;
    cdb_data = 32'hFFFF;
    next_cycle();
    cdb_valid = 1'b0;
    push(32'h400, 1'b0, 32'd2, 1'b0, 32'h1234, 5'd5);
    drain(1);

    // Full with simultaneous request: dequeue only, then accept and wrap
    for (int i = 0; i < 4; i++) begin
      drive(32'h500 + 32'(4 * i), 1'b0, 32'(i), 1'b0, 32'h0, 5'd6);
      push(32'h500 + 32'(4 * i), 1'b0, 32'(i), 1'b0, 32'h0, 5'd6);
      next_cycle();
    end
    drive(32'h510, 1'b0, 32'h77, 1'b0, 32'h0, 5'd7);
    out_ready = 1'b1;
    mid();
    check("full_in_ready", in_ready, 0);
    check("full_count",    count,    4);
    next_cycle();
    out_ready = 1'b0;
    mid();
    check("full_deq_count",    count,    3);
    check("full_deq_in_ready", in_ready, 1);
    push(32'h510, 1'b0, 32'h77, 1'b0, 32'h0, 5'd7);
    next_cycle();
    in_valid = 1'b0;
    mid();
    check("wrap_count", count, 4);
    next_cycle();
    drain(4);
    mid();
    check("wrap_drain_count", count, 0);
    next_cycle();

    // Flush with a concurrent enqueue
    for (int i = 0; i < 3; i++) begin
      drive(32'h600 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 32'h0, 5'd8);
      next_cycle();
    end
    mid();
    check("pre_flush_count", count, 3);
    drive(32'hBAD, 1'b0, 32'h0, 1'b0, 32'h0, 5'd8);
    flush = 1'b1;
    next_cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    mid();
    check("flush_count",     count,     0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready",  in_ready,  1);
    drive(32'h610, 1'b0, 32'h61, 1'b0, 32'h0, 5'd9);
    push(32'h610, 1'b0, 32'h61, 1'b0, 32'h0, 5'd9);
    next_cycle();
    in_valid = 1'b0;
    mid();
    check("post_flush_head",  out_pc, 32'h610);
    check("post_flush_count", count,  1);
    next_cycle();
    drain(1);

    // Reset mid-stream behaves like flush
    for (int i = 0; i < 3; i++) begin
      drive(32'h700 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 32'h0, 5'd10);
      next_cycle();
    end
    drive(32'hBAD, 1'b0, 32'h0, 1'b0, 32'h0, 5'd10);
    rst = 1'b0;
    next_cycle();
    rst      = 1'b1;
    in_valid = 1'b0;
    mid();
    check("rst_mid_count",     count,     0);
    check("rst_mid_out_valid", out_valid, 0);
    drive(32'h710, 1'b0, 32'h71, 1'b0, 32'h0, 5'd11);
    push(32'h710, 1'b0, 32'h71, 1'b0, 32'h0, 5'd11);
    next_cycle();
    in_valid = 1'b0;
    mid();
    check("post_rst_head", out_pc, 32'h710);
    next_cycle();
    drain(1);

    mid();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
